mem_port_arbiter: RTL and testbench

- Shares one single-ported 32-bit memory between the RV32I instruction-fetch requester and the data load/store requester.
- Sequences each access with a small FSM, generates byte enables and store-data lanes from the load/store funct3, and sign- or zero-extends load data.
- Detects misaligned or illegal data accesses and memory timeouts.
- Sits between the core's fetch/LSU stages and the memory bus.

---
 rtl/mem_port_arbiter_pkg.sv | 56 +++++
 rtl/mem_port_arbiter_lane_align.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state, owner,
// RV32I load/store funct3 encodings, memory request bundle and legality helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} arb_state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_t;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef struct packed {
    logic                  ren;
    logic                  wen;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [NUM_LANES-1:0]  be;
  } mreq_t;

  // Natural alignment of the access size; unknown funct3 values are never legal.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (f3)
        SB:      ok = 1'b1;
        SH:      ok = !a[0];
        SW:      ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        LB, LBU: ok = 1'b1;
        LH, LHU: ok = !a[0];
        LW:      ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// lsu_lane_align: combinational byte-lane steering. Request side builds byte
// enables, replicated store data and the misalign flag; response side extends load data.
module lsu_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic                 is_store_i,
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic [31:0]          wdata_i,
  output logic [NUM_LANES-1:0] byte_en_o,
  output logic [31:0]          wdata_o,
  output logic                 misalign_o,
  input  logic [2:0]           ld_funct3_i,
  input  logic [1:0]           ld_addr_lo_i,
  input  logic [31:0]          rdata_i,
  output logic [31:0]          rdata_o
);

  logic [NUM_LANES-1:0][LANE_W-1:0] wlane;
  logic [7:0]                       ld_b;
  logic [15:0]                      ld_h;

  // Each lane gets the byte it would carry for any store address of that size.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign wlane[k] = (funct3_i == SB) ? wdata_i[LANE_W-1:0] :
                      (funct3_i == SH) ? wdata_i[(k%2)*LANE_W +: LANE_W] :
                                         wdata_i[k*LANE_W +: LANE_W];
  end

  assign wdata_o    = is_store_i ? wlane : '0;
  assign misalign_o = !access_legal(is_store_i, funct3_i, addr_lo_i);

  always_comb begin
    byte_en_o = '1;
    if (is_store_i) begin
      case (funct3_i)
        SB:      byte_en_o = 4'b0001 << addr_lo_i;
        SH:      byte_en_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        default: byte_en_o = '1;
      endcase
    end
  end

  assign ld_b = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
  assign ld_h = rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    rdata_o = rdata_i;
    case (ld_funct3_i)
      LB:      rdata_o = {{24{ld_b[7]}}, ld_b};
      LBU:     rdata_o = {24'h0, ld_b};
      LH:      rdata_o = {{16{ld_h[15]}}, ld_h};
      LHU:     rdata_o = {16'h0, ld_h};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit single-ported memory between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit RESET_PC_OWNER = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        d_misalign,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  output logic        timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  owner_t      cur_q, cur_d;
  logic [15:0] cnt_q, cnt_d;
  mreq_t       mreq_q, mreq_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        st_q, st_d;
`ifdef ARB_ROUND_ROBIN_EN
  owner_t      rr_q, rr_d;
`endif

  logic        d_req, grant_d;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        req_illegal;
  logic        unused_addr_lo;

  assign unused_addr_lo = ^i_addr[1:0];
  assign d_req          = d_ren || d_wen;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the requester preferred on the next contention.
  assign grant_d = d_req && !(i_ren && (rr_q == OWN_I));
`else
  assign grant_d = d_req;
`endif

  lsu_lane_align u_align (
    .is_store_i   (d_wen),
    .funct3_i     (d_funct3),
    .addr_lo_i    (d_addr[1:0]),
    .wdata_i      (d_wdata),
    .byte_en_o    (st_be),
    .wdata_o      (st_wdata),
    .misalign_o   (req_illegal),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (alo_q),
    .rdata_i      (m_rdata),
    .rdata_o      (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    mreq_d    = mreq_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mis_d     = 1'b0;
    to_d      = 1'b0;
    f3_d      = f3_q;
    alo_d     = alo_q;
    st_d      = st_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          cur_d = OWN_D;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d  = OWN_I;
`endif
          if (req_illegal) begin
            state_d   = RESP;
            mis_d     = 1'b1;
            d_rdata_d = '0;
          end else begin
            state_d      = D_ACC;
            cnt_d        = '0;
            mreq_d.ren   = !d_wen;
            mreq_d.wen   = d_wen;
            mreq_d.addr  = {d_addr[31:2], 2'b00};
            mreq_d.wdata = st_wdata;
            mreq_d.be    = st_be;
            f3_d         = d_funct3;
            alo_d        = d_addr[1:0];
            st_d         = d_wen;
          end
        end else if (i_ren) begin
          cur_d   = OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d    = OWN_D;
`endif
          state_d = I_ACC;
          cnt_d   = '0;
          mreq_d  = '{ren: 1'b1, wen: 1'b0, addr: {i_addr[31:2], 2'b00}, wdata: '0, be: '1};
        end
      end
      I_ACC, D_ACC: begin
        // A still-busy memory on the last allowed cycle means the access is abandoned.
        if (!m_busy || (cnt_q == TO_LAST)) begin
          state_d = RESP;
          mreq_d  = '0;
          to_d    = m_busy;
          if (state_q == I_ACC) i_rdata_d = m_busy ? '0 : m_rdata;
          else                  d_rdata_d = (m_busy || st_q) ? '0 : ld_data;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cur_q     <= owner_t'(RESET_PC_OWNER);
      cnt_q     <= '0;
      mreq_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
      f3_q      <= '0;
      alo_q     <= '0;
      st_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q      <= owner_t'(RESET_PC_OWNER);
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      mreq_q    <= mreq_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
      f3_q      <= f3_d;
      alo_q     <= alo_d;
      st_q      <= st_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign m_ren       = mreq_q.ren;
  assign m_wen       = mreq_q.wen;
  assign m_addr      = mreq_q.addr;
  assign m_wdata     = mreq_q.wdata;
  assign m_byte_en   = mreq_q.be;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign d_misalign  = mis_q;
  assign timeout_err = to_q;
  assign i_busy      = i_ren && !((state_q == RESP) && (cur_q == OWN_I));
  assign d_busy      = d_req && !((state_q == RESP) && (cur_q == OWN_D));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, arbitration and
// reset sequences, then random transactions against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_ren, d_ren, d_wen, m_busy;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [2:0]  d_funct3;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_busy, d_busy, d_misalign, m_ren, m_wen, timeout_err;
  logic [3:0]  m_byte_en;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .RESET_PC_OWNER(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy),
    .d_ren(d_ren), .d_wen(d_wen), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_busy(d_busy), .d_misalign(d_misalign),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_busy(m_busy),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int lat; int acc;
    logic ren; logic wen;
    logic [31:0] maddr; logic [3:0] be; logic [31:0] mwd; logic [31:0] rd;
    logic chk_wd; logic chk_rd; logic mis; logic to;
  } exp_t;

  typedef struct {
    int lat; int acc;
    logic ren; logic wen;
    logic [31:0] maddr; logic [3:0] be; logic [31:0] mwd; logic [31:0] rd;
    logic mis; logic to; logic unstable;
  } obs_t;

  typedef struct {
    string nm; logic is_f; logic st; logic [2:0] f3;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] mword; int nb;
    exp_t e;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic is_f, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mword,
                     input int nb, input int lat, input int acc, input logic ren, input logic wen,
                     input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwd,
                     input logic [31:0] rd, input logic mis, input logic to);
    vec_t v;
    v.nm = nm; v.is_f = is_f; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.mword = mword; v.nb = nb;
    v.e.lat = lat; v.e.acc = acc; v.e.ren = ren; v.e.wen = wen; v.e.maddr = maddr;
    v.e.be = be; v.e.mwd = mwd; v.e.rd = rd; v.e.chk_wd = wen; v.e.chk_rd = !wen;
    v.e.mis = mis; v.e.to = to;
    tbl.push_back(v);
  endtask

  // Reference: outcome of one access derived from the alignment, lane and timeout rules.
  function automatic exp_t model(input logic is_f, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] mword, input int nb);
    exp_t e;
    int off;
    logic legal;
    logic [31:0] b, h;
    off = int'(addr % 4);
    e.ren = 0; e.wen = 0; e.maddr = 0; e.be = 0; e.mwd = 0; e.rd = 0;
    e.chk_wd = 0; e.chk_rd = 1; e.mis = 0; e.to = 0;
    if (is_f)    legal = 1;
    else if (st) legal = (f3 == 0) || (f3 == 1 && off % 2 == 0) || (f3 == 2 && off == 0);
    else         legal = (f3 == 0 || f3 == 4) || ((f3 == 1 || f3 == 5) && off % 2 == 0) ||
                         (f3 == 2 && off == 0);
    if (!legal) begin
      e.mis = 1; e.lat = 1; e.acc = 0;
      return e;
    end
    e.acc   = (nb < TO) ? nb + 1 : TO;
    e.lat   = e.acc + 1;
    e.to    = (nb >= TO);
    e.ren   = is_f || !st;
    e.wen   = !is_f && st;
    e.maddr = addr - 32'(off);
    e.be    = 4'hF;
    if (e.wen) begin
      if (f3 == 0)      begin e.be = 4'(1 << off); e.mwd = (wdata & 32'hFF) * 32'h0101_0101; end
      else if (f3 == 1) begin e.be = 4'(3 << off); e.mwd = (wdata & 32'hFFFF) * 32'h0001_0001; end
      else              e.mwd = wdata;
    end
    e.chk_wd = e.wen;
    e.chk_rd = !e.wen;
    b = (mword >> (8 * off)) & 32'hFF;
    h = (mword >> (8 * off)) & 32'hFFFF;
    if (is_f)         e.rd = mword;
    else if (f3 == 0) e.rd = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
    else if (f3 == 4) e.rd = b;
    else if (f3 == 1) e.rd = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
    else if (f3 == 5) e.rd = h;
    else              e.rd = mword;
    if (e.to) e.rd = 0;
    return e;
  endfunction

  // Drives one request from an IDLE cycle and plays a memory that stays busy nb cycles.
  task automatic run_op(input logic is_f, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mword, input int nb, output obs_t o);
    logic done;
    int acc;
    o.lat = -1; o.acc = 0; o.ren = 0; o.wen = 0; o.maddr = 0; o.be = 0; o.mwd = 0;
    o.rd = 0; o.mis = 0; o.to = 0; o.unstable = 0;
    @(posedge CLK); #1;
    i_ren = is_f; i_addr = addr;
    d_ren = !is_f && !st; d_wen = !is_f && st;
    d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    m_rdata = mword; m_busy = 0;
    done = 0; acc = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (m_ren || m_wen) begin
        if (acc == 0) begin
          o.ren = m_ren; o.wen = m_wen; o.maddr = m_addr; o.be = m_byte_en; o.mwd = m_wdata;
        end else if ({m_ren, m_wen, m_addr, m_byte_en, m_wdata} !==
                     {o.ren, o.wen, o.maddr, o.be, o.mwd}) begin
          o.unstable = 1;
        end
        acc++;
        m_busy = (acc <= nb);
      end
      if (!(is_f ? i_busy : d_busy)) begin
        o.lat = c; o.rd = is_f ? i_rdata : d_rdata;
        o.mis = d_misalign; o.to = timeout_err;
        done = 1;
      end
    end
    o.acc = acc;
    i_ren = 0; d_ren = 0; d_wen = 0; m_busy = 0;
  endtask

  task automatic check_op(input string tag, input logic is_f, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mword,
                          input int nb, input exp_t e);
    obs_t o;
    run_op(is_f, st, f3, addr, wdata, mword, nb, o);
    cmp({tag, ".latency"}, o.lat, e.lat);
    cmp({tag, ".strobe_cycles"}, o.acc, e.acc);
    cmp({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
    cmp({tag, ".timeout"}, 32'(o.to), 32'(e.to));
    if (e.acc > 0) begin
      cmp({tag, ".m_ren"}, 32'(o.ren), 32'(e.ren));
      cmp({tag, ".m_wen"}, 32'(o.wen), 32'(e.wen));
      cmp({tag, ".m_addr"}, o.maddr, e.maddr);
      cmp({tag, ".m_byte_en"}, 32'(o.be), 32'(e.be));
      cmp({tag, ".stable"}, 32'(o.unstable), 32'd0);
      if (e.chk_wd) cmp({tag, ".m_wdata"}, o.mwd, e.mwd);
    end
    if (e.chk_rd) cmp({tag, ".rdata"}, o.rd, e.rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name         f  s  f3    addr         wdata         mword         nb lat acc ren wen maddr        be     mwdata        rdata         mis to
    add("lw_basic",   0, 0, 3'd2, 32'h100,     32'h0,        32'hDEADBEEF, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'hDEADBEEF, 0, 0);
    add("lb_sign",    0, 0, 3'd0, 32'h103,     32'h0,        32'h80FFFFFF, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'hFFFFFF80, 0, 0);
    add("lbu_zero",   0, 0, 3'd4, 32'h103,     32'h0,        32'h80FFFFFF, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'h00000080, 0, 0);
    add("sh_upper",   0, 1, 3'd1, 32'h202,     32'h1234ABCD, 32'h0,        1, 3, 2, 0, 1, 32'h200,     4'hC, 32'hABCDABCD, 32'h0,        0, 0);
    add("lw_misal",   0, 0, 3'd2, 32'h101,     32'h0,        32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0,        1, 0);
    add("ld_f3_011",  0, 0, 3'd3, 32'h100,     32'h0,        32'hDEADBEEF, 0, 1, 0, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0,        1, 0);
    add("sb_lane1",   0, 1, 3'd0, 32'h101,     32'h0000005A, 32'h0,        0, 2, 1, 0, 1, 32'h100,     4'h2, 32'h5A5A5A5A, 32'h0,        0, 0);
    add("sb_lane3",   0, 1, 3'd0, 32'h103,     32'hFFFFFF77, 32'h0,        0, 2, 1, 0, 1, 32'h100,     4'h8, 32'h77777777, 32'h0,        0, 0);
    add("lhu_hi",     0, 0, 3'd5, 32'h102,     32'h0,        32'h80011234, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'h00008001, 0, 0);
    add("lh_hi",      0, 0, 3'd1, 32'h102,     32'h0,        32'h80011234, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'hFFFF8001, 0, 0);
    add("lh_lo",      0, 0, 3'd1, 32'h100,     32'h0,        32'h80011234, 0, 2, 1, 1, 0, 32'h100,     4'hF, 32'h0,        32'h00001234, 0, 0);
    add("sw_busy3",   0, 1, 3'd2, 32'h30C,     32'hCAFEF00D, 32'h0,        3, 5, 4, 0, 1, 32'h30C,     4'hF, 32'hCAFEF00D, 32'h0,        0, 0);
    add("st_f3_011",  0, 1, 3'd3, 32'h300,     32'h11111111, 32'h0,        0, 1, 0, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0,        1, 0);
    add("lh_odd",     0, 0, 3'd1, 32'h103,     32'h0,        32'h55555555, 0, 1, 0, 0, 0, 32'h0,       4'h0, 32'h0,        32'h0,        1, 0);
    add("lw_timeout", 0, 0, 3'd2, 32'h104,     32'h0,        32'h12345678, 7, 5, 4, 1, 0, 32'h104,     4'hF, 32'h0,        32'h0,        0, 1);
    add("if_basic",   1, 0, 3'd0, 32'h1003,    32'h0,        32'h00000013, 0, 2, 1, 1, 0, 32'h1000,    4'hF, 32'h0,        32'h00000013, 0, 0);
    add("if_timeout", 1, 0, 3'd0, 32'h2000,    32'h0,        32'hFFFFFFFF, 4, 5, 4, 1, 0, 32'h2000,    4'hF, 32'h0,        32'h0,        0, 1);

    RST = 1; i_ren = 0; d_ren = 0; d_wen = 0; m_busy = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0; m_rdata = 0;
    #3;
    cmp("rst.m_ren", 32'(m_ren), 32'd0);
    cmp("rst.m_wen", 32'(m_wen), 32'd0);
    cmp("rst.m_addr", m_addr, 32'd0);
    cmp("rst.m_wdata", m_wdata, 32'd0);
    cmp("rst.m_byte_en", 32'(m_byte_en), 32'd0);
    cmp("rst.i_rdata", i_rdata, 32'd0);
    cmp("rst.d_rdata", d_rdata, 32'd0);
    cmp("rst.pulses", 32'({d_misalign, timeout_err}), 32'd0);
    repeat (2) @(negedge CLK);
    RST = 0;

    for (int i = 0; i < tbl.size(); i++)
      check_op(tbl[i].nm, tbl[i].is_f, tbl[i].st, tbl[i].f3, tbl[i].addr,
               tbl[i].wdata, tbl[i].mword, tbl[i].nb, tbl[i].e);

    // Both requesters held through four grants.
    begin
      logic prev;
      int ng;
      logic [3:0] got, want;
      @(posedge CLK); #1;
      i_ren = 1; i_addr = 32'h400; d_ren = 1; d_wen = 0; d_funct3 = 3'd2;
      d_addr = 32'h800; m_busy = 0; m_rdata = 32'h0;
      prev = 0; ng = 0; got = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
        @(negedge CLK);
        if (m_ren && !prev) begin
          got[ng] = (m_addr == 32'h800);
          ng++;
        end
        prev = m_ren;
      end
      i_ren = 0; d_ren = 0;
`ifdef ARB_ROUND_ROBIN_EN
      want = 4'b0101;
`else
      want = 4'b1111;
`endif
      cmp("arb.grant_count", ng, 4);
      cmp("arb.grant_order", 32'(got), 32'(want));
      repeat (3) @(posedge CLK);
    end

    // Asynchronous reset in the middle of a stalled data access.
    @(posedge CLK); #1;
    d_ren = 1; d_wen = 0; d_funct3 = 3'd2; d_addr = 32'h500; m_busy = 1;
    @(negedge CLK);
    @(negedge CLK);
    cmp("rstmid.m_ren_before", 32'(m_ren), 32'd1);
    #2 RST = 1;
    #1;
    cmp("rstmid.m_ren_after", 32'(m_ren), 32'd0);
    cmp("rstmid.m_addr_after", m_addr, 32'd0);
    d_ren = 0; m_busy = 0;
    @(negedge CLK);
    RST = 0;
    check_op("post_rst", tbl[0].is_f, tbl[0].st, tbl[0].f3, tbl[0].addr,
             tbl[0].wdata, tbl[0].mword, tbl[0].nb, tbl[0].e);

    for (int k = 0; k < 150; k++) begin
      logic is_f, st;
      logic [2:0] f3;
      logic [31:0] a, wd, mw;
      int nb;
      is_f = ($urandom_range(0, 3) == 0);
      st   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      wd   = $urandom;
      mw   = $urandom;
      nb   = $urandom_range(0, 5);
      check_op($sformatf("rnd%0d", k), is_f, st, f3, a, wd, mw, nb,
               model(is_f, st, f3, a, wd, mw, nb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
